// File: rtl/int_sched_if.sv
// Signal bundle between the raster interrupt scheduler and the CPU/video side.
// The missed flag exists only when INT_SCHED_TIMEOUT_EN is defined.
interface int_sched_if #(
  parameter int NSLOT  = 4,
  parameter int LINE_W = 9,
  parameter int HPOS_W = 8
);
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [7:0]        wr_data;
  logic [LINE_W-1:0] line;
  logic [HPOS_W-1:0] hpos;
  logic              pix_stb;
  logic              frame_start;
  logic              vdos;
  logic              intack;
  logic              int_start_lin;
  logic [1:0]        slot_id;
  logic [NSLOT-1:0]  pending;
  logic              overflow;
`ifdef INT_SCHED_TIMEOUT_EN
  logic              missed;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, line, hpos, pix_stb, frame_start, vdos, intack,
    input  int_start_lin, slot_id, pending, overflow
`ifdef INT_SCHED_TIMEOUT_EN
    , input missed
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, line, hpos, pix_stb, frame_start, vdos, intack,
    output int_start_lin, slot_id, pending, overflow
`ifdef INT_SCHED_TIMEOUT_EN
    , output missed
`endif
  );
endinterface

// File: rtl/int_sched.sv
// Raster-interrupt scheduler: slot compare -> pending (+1 clk) -> start pulse (+1 clk), paced by intack edges.
// vdos defers issue without losing hits; INT_SCHED_TIMEOUT_EN adds a 63-clk ack timeout and sticky missed flag.
module int_sched #(
  parameter int NSLOT  = 4,
  parameter int LINE_W = 9,
  parameter int HPOS_W = 8
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  int_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK} state_t;

  state_t            r_state, w_state_nxt;
  logic [LINE_W-1:0] r_line [NSLOT];
  logic [HPOS_W-1:0] r_hpos [NSLOT];
  logic [NSLOT-1:0]  r_en, r_os, r_pending;
  logic [NSLOT-1:0]  w_hit, w_wr_slot, w_iss_clr;
  logic              r_overflow, r_ack_d;
  logic [1:0]        r_slot_id, w_sel;
  logic              w_ack_edge, w_ctl, w_issue, w_any, w_ovf, w_start;
`ifdef INT_SCHED_TIMEOUT_EN
  logic [5:0]        r_to_cnt;
  logic              r_missed, w_to;
`endif

  assign w_ack_edge = bus.intack & ~r_ack_d;
  assign w_ctl      = bus.wr_en && (bus.wr_addr == 5'd16);
  assign w_any      = |r_pending;

  // Per-slot compare, write decode and lowest-index pending select.
  always_comb begin
    w_hit     = '0;
    w_wr_slot = '0;
    w_iss_clr = '0;
    w_sel     = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      w_hit[i]     = bus.pix_stb && r_en[i] && (bus.line == r_line[i]) && (bus.hpos == r_hpos[i]);
      w_wr_slot[i] = bus.wr_en && !bus.wr_addr[4] && (bus.wr_addr[3:2] == 2'(i))
                     && (bus.wr_addr[1:0] != 2'd3);
      if (r_pending[i]) w_sel = 2'(i);
    end
    for (int i = 0; i < NSLOT; i++) begin
      w_iss_clr[i] = w_issue && r_pending[i] && (w_sel == 2'(i));
    end
  end

  // A hit on a slot being issued this clk is a fresh request, not an overflow.
  assign w_ovf = |(w_hit & r_pending & ~w_wr_slot & ~w_iss_clr);

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      for (int i = 0; i < NSLOT; i++) begin
        r_line[i] <= '0;
        r_hpos[i] <= '0;
      end
      r_en       <= '0;
      r_os       <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (w_iss_clr[i] && r_os[i]) r_en[i] <= 1'b0;
        if (w_wr_slot[i]) begin
          case (bus.wr_addr[1:0])
            2'd0: r_line[i][7:0] <= bus.wr_data;
            2'd1: begin
              r_en[i]             <= bus.wr_data[7];
              r_os[i]             <= bus.wr_data[6];
              r_line[i][LINE_W-1] <= bus.wr_data[0];
            end
            2'd2:    r_hpos[i] <= bus.wr_data[HPOS_W-1:0];
            default: ;
          endcase
        end
        if (w_wr_slot[i])
          r_pending[i] <= 1'b0;
        else if (w_hit[i])
          r_pending[i] <= 1'b1;
        else if (bus.frame_start || (w_ctl && bus.wr_data[1]) || w_iss_clr[i])
          r_pending[i] <= 1'b0;
      end
      r_overflow <= (r_overflow & ~(w_ctl & bus.wr_data[0])) | w_ovf;
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state   <= S_IDLE;
      r_ack_d   <= 1'b0;
      r_slot_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack_d <= bus.intack;
      if (w_issue) r_slot_id <= w_sel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: if (w_any && !bus.vdos) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_start     = 1'b1;
        w_issue     = 1'b1;
        w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (w_ack_edge || bus.frame_start) w_state_nxt = S_IDLE;
`ifdef INT_SCHED_TIMEOUT_EN
        else if (r_to_cnt == 6'd62) w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef INT_SCHED_TIMEOUT_EN
  // The counter is zeroed while issuing, so WAIT_ACK lasts at most 63 clk.
  assign w_to = (r_state == S_WAIT_ACK) && !w_ack_edge && !bus.frame_start && (r_to_cnt == 6'd62);

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_to_cnt <= '0;
      r_missed <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_to_cnt <= '0;
      else if (r_state == S_WAIT_ACK)
        r_to_cnt <= r_to_cnt + 6'd1;
      r_missed <= (r_missed & ~(w_ctl & bus.wr_data[2])) | w_to;
    end
  end

  assign bus.missed = r_missed;
`endif

  assign bus.int_start_lin = w_start;
  assign bus.slot_id       = r_slot_id;
  assign bus.pending       = r_pending;
  assign bus.overflow      = r_overflow;

endmodule

// File: tb/tb_int_sched.sv
// Directed bench for int_sched: slot match, queueing, oneshot, overflow, vdos deferral, reset, optional timeout.
module tb_int_sched;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  int_sched_if #(.NSLOT(4), .LINE_W(9), .HPOS_W(8)) bus ();

  int_sched #(.NSLOT(4), .LINE_W(9), .HPOS_W(8)) dut (
    .i_clk   (clk),
    .i_res_n (res_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
  endtask

  task automatic hit(input logic [8:0] l, input logic [7:0] h);
    bus.line = l; bus.hpos = h; bus.pix_stb = 1'b1;
    tick();
    bus.pix_stb = 1'b0;
  endtask

  task automatic ack();
    bus.intack = 1'b1;
    tick(); tick(); tick();
    bus.intack = 1'b0;
    tick();
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.line = '0; bus.hpos = '0; bus.pix_stb = 1'b0;
    bus.frame_start = 1'b0; bus.vdos = 1'b0; bus.intack = 1'b0;

    #2;
    chk("rst_int", bus.int_start_lin, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_slot_id", bus.slot_id, 0);
`ifdef INT_SCHED_TIMEOUT_EN
    chk("rst_missed", bus.missed, 0);
`endif
    #10 res_n = 1'b1;
    tick();

    // Single slot: slot0 line 0x105, hpos 0x20, enabled, repeating
    wr(5'd0, 8'h05); wr(5'd1, 8'h81); wr(5'd2, 8'h20);
    hit(9'h105, 8'h20);
    chk("t1_pending", bus.pending, 4'b0001);
    chk("t1_no_early", bus.int_start_lin, 0);
    tick();
    chk("t1_pulse", bus.int_start_lin, 1);
    tick();
    chk("t1_pulse_1clk", bus.int_start_lin, 0);
    chk("t1_slot_id", bus.slot_id, 0);
    chk("t1_pend_clr", bus.pending, 0);
    ack();
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    hit(9'h105, 8'h20);
    tick();
    chk("t1_refire", bus.int_start_lin, 1);
    tick();
    ack();

    // Priority: slots 1 and 2 share a position
    wr(5'd4, 8'h10); wr(5'd5, 8'h80); wr(5'd6, 8'h40);
    wr(5'd8, 8'h10); wr(5'd9, 8'h80); wr(5'd10, 8'h40);
    hit(9'h010, 8'h40);
    chk("pr_pending", bus.pending, 4'b0110);
    tick();
    chk("pr_pulse1", bus.int_start_lin, 1);
    tick();
    chk("pr_slot1", bus.slot_id, 1);
    chk("pr_pend_after1", bus.pending, 4'b0100);
    tick();
    chk("pr_wait_ack", bus.int_start_lin, 0);
    bus.intack = 1'b1;
    tick();
    chk("pr_idle", bus.int_start_lin, 0);
    tick();
    chk("pr_pulse2", bus.int_start_lin, 1);
    bus.intack = 1'b0;
    tick();
    chk("pr_slot2", bus.slot_id, 2);
    chk("pr_pend_end", bus.pending, 0);
    ack();

    // Oneshot on slot3
    wr(5'd12, 8'h20); wr(5'd13, 8'hC0); wr(5'd14, 8'h10);
    hit(9'h020, 8'h10);
    tick();
    chk("os_pulse", bus.int_start_lin, 1);
    tick();
    chk("os_slot3", bus.slot_id, 3);
    ack();
    hit(9'h020, 8'h10);
    chk("os_disabled", bus.pending, 0);
    tick();
    chk("os_no_refire", bus.int_start_lin, 0);

    // vdos deferral and overflow
    bus.vdos = 1'b1;
    hit(9'h105, 8'h20);
    chk("vd_pending", bus.pending, 4'b0001);
    tick(); tick();
    chk("vd_blocked", bus.int_start_lin, 0);
    hit(9'h105, 8'h20);
    chk("ov_set", bus.overflow, 1);
    chk("ov_pend_kept", bus.pending, 4'b0001);
    wr(5'd16, 8'h01);
    chk("ov_clear", bus.overflow, 0);
    chk("ov_clr_keeps_pend", bus.pending, 4'b0001);
    bus.vdos = 1'b0;
    tick();
    chk("vd_release_pulse", bus.int_start_lin, 1);
    tick();
    chk("vd_slot0", bus.slot_id, 0);
    chk("vd_pend_clr", bus.pending, 0);
    ack();

    // Pending clear sources, under vdos so nothing issues
    bus.vdos = 1'b1;
    hit(9'h105, 8'h20);
    wr(5'd16, 8'h02);
    chk("ctl_clr_pending", bus.pending, 0);
    hit(9'h105, 8'h20);
    wr(5'd2, 8'h20);
    chk("wr_clr_pending", bus.pending, 0);
    bus.line = 9'h105; bus.hpos = 8'h20; bus.pix_stb = 1'b1;
    wr(5'd2, 8'h20);
    bus.pix_stb = 1'b0;
    chk("wr_beats_match", bus.pending, 0);
    hit(9'h105, 8'h20);
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    chk("fs_clr_pending", bus.pending, 0);
    bus.frame_start = 1'b1;
    hit(9'h105, 8'h20);
    bus.frame_start = 1'b0;
    chk("fs_match_wins", bus.pending, 4'b0001);
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    bus.vdos = 1'b0;
    tick(); tick();
    chk("no_stale_pulse", bus.int_start_lin, 0);

    // Reset while waiting for ack with hits queued
    hit(9'h010, 8'h40);
    tick(); tick();
    hit(9'h105, 8'h20);
    hit(9'h105, 8'h20);
    chk("mr_pending", bus.pending, 4'b0101);
    chk("mr_overflow", bus.overflow, 1);
    chk("mr_slot", bus.slot_id, 1);
    #2 res_n = 1'b0;
    #1;
    chk("mr_rst_pending", bus.pending, 0);
    chk("mr_rst_overflow", bus.overflow, 0);
    chk("mr_rst_slot", bus.slot_id, 0);
    chk("mr_rst_int", bus.int_start_lin, 0);
    #4 res_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_quiet", bus.int_start_lin, 0);
    end
    hit(9'h105, 8'h20);
    chk("mr_slots_disabled", bus.pending, 0);
    wr(5'd0, 8'h05); wr(5'd1, 8'h81); wr(5'd2, 8'h20);
    hit(9'h105, 8'h20);
    tick();
    chk("mr_new_pulse", bus.int_start_lin, 1);

`ifdef INT_SCHED_TIMEOUT_EN
    tick();
    hit(9'h105, 8'h20);
    repeat (61) tick();
    chk("to_not_yet", bus.missed, 0);
    chk("to_no_pulse", bus.int_start_lin, 0);
    tick();
    chk("to_missed", bus.missed, 1);
    tick();
    chk("to_next_issue", bus.int_start_lin, 1);
    tick();
    wr(5'd16, 8'h04);
    chk("to_missed_clr", bus.missed, 0);
    ack();
`else
    tick();
    ack();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
